memory_write_buffer: RTL and testbench

MEMORY_WRITE_BUFFER -- requirements
Module: memory_write_buffer

---
 rtl/memory_write_buffer_pkg.sv | 14 +
 rtl/memory_write_buffer_fifo.sv | 72 +++++++
 rtl/memory_write_buffer.sv | 147 ++++++++++++++
 tb/tb_memory_write_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_write_buffer_pkg.sv
// Shared definitions for the memory write buffer: default sizes and the drain FSM encoding.
package memory_write_buffer_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RD_WAIT = 2'd2
    } wb_state_t;

endpackage

// File: rtl/memory_write_buffer_fifo.sv
// wb_fifo: circular entry storage for the write buffer (address + data per entry).
// With WB_FORWARD_EN defined, the raw entries and read pointer are exported for address matching.
module wb_fifo
    import memory_write_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = WB_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_pushAddr,
    input  logic [DATA_WIDTH-1:0] i_pushData,
    input  logic                  i_pop,
    output logic [ADDR_WIDTH-1:0] o_headAddr,
    output logic [DATA_WIDTH-1:0] o_headData,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [PTR_W:0]        o_count
`ifdef WB_FORWARD_EN
    ,
    output logic [PTR_W-1:0]      o_rdPtr,
    output logic [ADDR_WIDTH-1:0] o_entryAddr [DEPTH],
    output logic [DATA_WIDTH-1:0] o_entryData [DEPTH]
`endif
);

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W:0]        r_count;

    // Entry payloads need no reset: only slots below the count are ever observed.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wrPtr] <= i_pushAddr;
            r_data[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_headAddr = r_addr[r_rdPtr];
    assign o_headData = r_data[r_rdPtr];
    assign o_full     = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

`ifdef WB_FORWARD_EN
    assign o_rdPtr     = r_rdPtr;
    assign o_entryAddr = r_addr;
    assign o_entryData = r_data;
`endif

endmodule

// File: rtl/memory_write_buffer.sv
// FIFO write buffer between the cache controller and data memory; reads are ordered behind buffered writes.
// Optional WB_FORWARD_EN: reads hitting a buffered address return the youngest matching data without a memory access.
module memory_write_buffer
    import memory_write_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_up,
    input  logic                  wr_up,
    input  logic [ADDR_WIDTH-1:0] addr_up,
    input  logic [DATA_WIDTH-1:0] wdata_up,
    output logic [DATA_WIDTH-1:0] rdata_up,
    output logic                  ready_up,
    output logic                  rd_mem,
    output logic                  wr_mem,
    output logic [ADDR_WIDTH-1:0] addr_mem,
    output logic [DATA_WIDTH-1:0] wdata_mem,
    input  logic [DATA_WIDTH-1:0] rdata_mem,
    input  logic                  ready_mem
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_state_t             r_state;
    wb_state_t             w_nextState;
    logic                  r_readyUp;
    logic [DATA_WIDTH-1:0] r_rdataUp;
    logic [ADDR_WIDTH-1:0] w_headAddr;
    logic [DATA_WIDTH-1:0] w_headData;
    logic                  w_full;
    logic                  w_empty;
    logic [PTR_W:0]        w_count;
    logic                  w_pop;
    logic                  w_reqOpen;
    logic                  w_wrAccept;
    logic                  w_rdReq;
    logic                  w_rdDone;
    logic                  w_fwdHit;
    logic [DATA_WIDTH-1:0] w_fwdData;

    // Requests are ignored during the ready turnaround and while a memory read is outstanding.
    assign w_reqOpen  = !r_readyUp && (r_state != RD_WAIT);
    assign w_pop      = (r_state == DRAIN) && ready_mem && !w_empty;
    assign w_wrAccept = wr_up && w_reqOpen && (!w_full || w_pop);
    assign w_rdReq    = rd_up && !wr_up && w_reqOpen;
    assign w_rdDone   = (r_state == RD_WAIT) && ready_mem;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0]      w_rdPtr;
    logic [PTR_W-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0] w_entryAddr [DEPTH];
    logic [DATA_WIDTH-1:0] w_entryData [DEPTH];

    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        w_fwdHit  = 1'b0;
        w_fwdData = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = w_rdPtr + PTR_W'(i);
            if (((PTR_W + 1)'(i) < w_count) && (w_entryAddr[w_idx] == addr_up)) begin
                w_fwdHit  = 1'b1;
                w_fwdData = w_entryData[w_idx];
            end
        end
    end
`else
    assign w_fwdHit  = 1'b0;
    assign w_fwdData = '0;
`endif

    wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_wrAccept),
        .i_pushAddr (addr_up),
        .i_pushData (wdata_up),
        .i_pop      (w_pop),
        .o_headAddr (w_headAddr),
        .o_headData (w_headData),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
`ifdef WB_FORWARD_EN
        ,
        .o_rdPtr     (w_rdPtr),
        .o_entryAddr (w_entryAddr),
        .o_entryData (w_entryData)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_readyUp <= 1'b0;
            r_rdataUp <= '0;
        end else begin
            r_state   <= w_nextState;
            r_readyUp <= w_wrAccept || (w_rdReq && w_fwdHit) || w_rdDone;
            if (w_rdReq && w_fwdHit)
                r_rdataUp <= w_fwdData;
            else if (w_rdDone)
                r_rdataUp <= rdata_mem;
        end
    end

    // Memory strobes decode straight from the state, so an async reset drops them at once.
    always_comb begin
        w_nextState = r_state;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        addr_mem    = '0;
        wdata_mem   = '0;
        case (r_state)
            IDLE: begin
                if (w_count != '0)
                    w_nextState = DRAIN;
                else if (w_rdReq && !w_fwdHit)
                    w_nextState = RD_WAIT;
            end
            DRAIN: begin
                wr_mem    = 1'b1;
                addr_mem  = w_headAddr;
                wdata_mem = w_headData;
                if (ready_mem) w_nextState = IDLE;
            end
            RD_WAIT: begin
                rd_mem   = 1'b1;
                addr_mem = addr_up;
                if (ready_mem) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign ready_up = r_readyUp;
    assign rdata_up = r_rdataUp;

endmodule

// File: tb/tb_memory_write_buffer.sv
// Directed self-checking bench for memory_write_buffer (default sizes; WB_FORWARD_EN-aware expectations).
module tb_memory_write_buffer;

    logic        clk;
    logic        reset;
    logic        rd_up;
    logic        wr_up;
    logic [31:0] addr_up;
    logic [31:0] wdata_up;
    logic [31:0] rdata_up;
    logic        ready_up;
    logic        rd_mem;
    logic        wr_mem;
    logic [31:0] addr_mem;
    logic [31:0] wdata_mem;
    logic [31:0] rdata_mem;
    logic        ready_mem;

    int testsRun    = 0;
    int testsFailed = 0;
    int overlapSeen = 0;

    memory_write_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .rd_up     (rd_up),
        .wr_up     (wr_up),
        .addr_up   (addr_up),
        .wdata_up  (wdata_up),
        .rdata_up  (rdata_up),
        .ready_up  (ready_up),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .addr_mem  (addr_mem),
        .wdata_mem (wdata_mem),
        .rdata_mem (rdata_mem),
        .ready_mem (ready_mem)
    );

    always #5 clk = ~clk;

    // Both memory strobes high together is never legal.
    always @(negedge clk) begin
        if (rd_mem && wr_mem) overlapSeen++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold a write request until ready_up is seen; latency counts rising edges.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, output int latency);
        wr_up    = 1'b1;
        addr_up  = a;
        wdata_up = d;
        latency  = 0;
        do begin
            tick();
            latency++;
        end while (!ready_up && latency < 20);
        wr_up = 1'b0;
    endtask

    // Wait for the next write strobe, check its payload, then complete it.
    task automatic drainOne(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!wr_mem && n < 20) begin
            tick();
            n++;
        end
        checkOutput("drain strobe", wr_mem, 1);
        checkOutput("drain addr", addr_mem, a);
        checkOutput("drain data", wdata_mem, d);
        ready_mem = 1'b1;
        tick();
        ready_mem = 1'b0;
        checkOutput("drain strobe gap", wr_mem, 0);
    endtask

    task automatic quietCycles(input string tag, input int cycles);
        int strobes = 0;
        repeat (cycles) begin
            tick();
            if (wr_mem || rd_mem) strobes++;
        end
        checkOutput(tag, strobes, 0);
    endtask

    initial begin
        int lat;
        int stalls;
        clk       = 1'b0;
        reset     = 1'b1;
        rd_up     = 1'b0;
        wr_up     = 1'b0;
        addr_up   = '0;
        wdata_up  = '0;
        rdata_mem = '0;
        ready_mem = 1'b0;
        tick();
        tick();
        checkOutput("reset ready_up", ready_up, 0);
        checkOutput("reset rd_mem", rd_mem, 0);
        checkOutput("reset wr_mem", wr_mem, 0);
        checkOutput("reset addr_mem", addr_mem, 0);
        checkOutput("reset wdata_mem", wdata_mem, 0);
        checkOutput("reset rdata_up", rdata_up, 0);
        reset = 1'b0;
        tick();

        // Stray ready_mem while idle does nothing.
        ready_mem = 1'b1;
        tick();
        ready_mem = 1'b0;
        checkOutput("stray ready_mem ready_up", ready_up, 0);
        checkOutput("stray ready_mem wr_mem", wr_mem, 0);

        // Single write.
        applyStimulus(32'h10, 32'hDEADBEEF, lat);
        checkOutput("single write latency", lat, 1);
        checkOutput("single write strobe not yet", wr_mem, 0);
        tick();
        tick();
        drainOne(32'h10, 32'hDEADBEEF);
        quietCycles("single write empty after", 4);

        // Fill to depth with memory stalled, then a fifth write waits for the pop.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h100 + i, 32'h1000 + i, lat);
            checkOutput("burst latency", lat, (i == 0) ? 1 : 2);
        end
        wr_up    = 1'b1;
        addr_up  = 32'h104;
        wdata_up = 32'h1004;
        stalls   = 0;
        repeat (4) begin
            tick();
            if (ready_up) stalls++;
        end
        checkOutput("full write stalled", stalls, 0);
        checkOutput("full head addr", addr_mem, 32'h100);
        checkOutput("full head data", wdata_mem, 32'h1000);
        ready_mem = 1'b1;
        tick();
        ready_mem = 1'b0;
        wr_up     = 1'b0;
        checkOutput("full write accepted on pop", ready_up, 1);
        for (int i = 1; i < 5; i++) drainOne(32'h100 + i, 32'h1000 + i);

        // Read miss ordered after a buffered write, memory latency 3.
        applyStimulus(32'h20, 32'h1, lat);
        rd_up   = 1'b1;
        addr_up = 32'h30;
        checkOutput("read waits rd_mem", rd_mem, 0);
        drainOne(32'h20, 32'h1);
        checkOutput("read after drain rd_mem low", rd_mem, 0);
        tick();
        checkOutput("read rd_mem", rd_mem, 1);
        checkOutput("read addr_mem", addr_mem, 32'h30);
        tick();
        tick();
        checkOutput("read rd_mem held", rd_mem, 1);
        ready_mem = 1'b1;
        rdata_mem = 32'hCAFE0030;
        tick();
        ready_mem = 1'b0;
        rd_up     = 1'b0;
        checkOutput("read ready_up", ready_up, 1);
        checkOutput("read rdata_up", rdata_up, 32'hCAFE0030);
        checkOutput("read rd_mem released", rd_mem, 0);
        tick();
        checkOutput("read ready_up one cycle", ready_up, 0);

        // Two writes to one address, then a read of it.
        applyStimulus(32'h40, 32'hA, lat);
        applyStimulus(32'h40, 32'hB, lat);
        rd_up   = 1'b1;
        addr_up = 32'h40;
`ifdef WB_FORWARD_EN
        tick();
        tick();
        checkOutput("forward ready_up", ready_up, 1);
        checkOutput("forward rdata_up", rdata_up, 32'hB);
        checkOutput("forward no rd_mem", rd_mem, 0);
        rd_up = 1'b0;
        drainOne(32'h40, 32'hA);
        drainOne(32'h40, 32'hB);
        quietCycles("forward no later strobe", 4);
`else
        drainOne(32'h40, 32'hA);
        drainOne(32'h40, 32'hB);
        tick();
        checkOutput("same addr rd_mem", rd_mem, 1);
        checkOutput("same addr addr_mem", addr_mem, 32'h40);
        ready_mem = 1'b1;
        rdata_mem = 32'hB;
        tick();
        ready_mem = 1'b0;
        rd_up     = 1'b0;
        checkOutput("same addr ready_up", ready_up, 1);
        checkOutput("same addr rdata_up", rdata_up, 32'hB);
`endif

        // Read and write together: write first, read later.
        tick();
        wr_up    = 1'b1;
        rd_up    = 1'b1;
        addr_up  = 32'h50;
        wdata_up = 32'h5;
        tick();
        wr_up = 1'b0;
        checkOutput("both write ready_up", ready_up, 1);
`ifdef WB_FORWARD_EN
        tick();
        tick();
        checkOutput("both read forwarded", ready_up, 1);
        checkOutput("both read data", rdata_up, 32'h5);
        rd_up = 1'b0;
        drainOne(32'h50, 32'h5);
`else
        drainOne(32'h50, 32'h5);
        tick();
        checkOutput("both read rd_mem", rd_mem, 1);
        checkOutput("both read addr", addr_mem, 32'h50);
        ready_mem = 1'b1;
        rdata_mem = 32'h5;
        tick();
        ready_mem = 1'b0;
        rd_up     = 1'b0;
        checkOutput("both read ready_up", ready_up, 1);
        checkOutput("both read data", rdata_up, 32'h5);
`endif

        // Reset mid-drain with three entries buffered.
        tick();
        for (int i = 0; i < 3; i++) applyStimulus(32'h200 + i, 32'h2000 + i, lat);
        checkOutput("pre-reset wr_mem", wr_mem, 1);
        #3 reset = 1'b1;
        #1;
        checkOutput("async reset wr_mem", wr_mem, 0);
        checkOutput("async reset ready_up", ready_up, 0);
        checkOutput("async reset addr_mem", addr_mem, 0);
        tick();
        tick();
        reset = 1'b0;
        quietCycles("no strobes after reset", 6);
        applyStimulus(32'h60, 32'h6, lat);
        checkOutput("post-reset write latency", lat, 1);
        drainOne(32'h60, 32'h6);
        quietCycles("post-reset buffer empty", 4);

        checkOutput("rd_mem/wr_mem exclusive", overlapSeen, 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
